mcb_port_arb: RTL and testbench

Two-requester arbiter and scheduler in front of the MCB native command interface (mcb_bb/mcb_wr_n/mcb_bl/mcb_ba/mcb_ra/mcb_ca). It shares the single MCB port between requester p0 and requester p1 using round-robin. It tracks outstanding bursts in order, so read beats (mcb_rdat_vld) and write-data requests (mcb_wdat_req) are steered to the requester that owns each burst. It sits between the front-end wrappers and MCB_TOP, in the MCB clock domain.

---
 rtl/mcb_arb_pkg.sv | 33 +++
 rtl/mcb_arb_tag_fifo.sv | 53 +++++
 rtl/mcb_port_arb.sv | 229 ++++++++++++++++++++++
 tb/tb_mcb_port_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_arb_pkg.sv
// Shared types and helpers for the two-port MCB command arbiter.
// Burst-length coding, outstanding-burst tag layout and FSM encoding live here.
package mcb_arb_pkg;

    localparam logic [1:0] BL_1 = 2'b00;
    localparam logic [1:0] BL_2 = 2'b01;
    localparam logic [1:0] BL_4 = 2'b10;
    localparam logic [1:0] BL_8 = 2'b11;

    localparam int PORT_W = 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [1:0]        bl;
    } tag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    function automatic logic [3:0] bl_beats(input logic [1:0] bl);
        logic [3:0] beats;
        case (bl)
            BL_1:    beats = 4'd1;
            BL_2:    beats = 4'd2;
            BL_4:    beats = 4'd4;
            default: beats = 4'd8;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/mcb_arb_tag_fifo.sv
// Outstanding-burst tag FIFO; push and pop may coincide even when full or empty.
// Pointers carry one extra wrap bit so full/empty fall out of a compare.
module mcb_arb_tag_fifo
    import mcb_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_data,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    tag_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot a full FIFO needs for the push.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mcb_port_arb.sv
// Round-robin arbiter sharing one MCB native command port between p0 and p1,
// steering read beats and write-data requests to the owner of each in-order burst.
module mcb_port_arb
    import mcb_arb_pkg::*;
#(
    parameter int MCB_B_W   = 2,
    parameter int MCB_R_W   = 13,
    parameter int MCB_C_W   = 9,
    parameter int MCB_D_W   = 32,
    parameter int MCB_BE_W  = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                mcb_clk,
    input  logic                mcb_rst,
    input  logic                p0_req,
    input  logic                p0_wr_n,
    input  logic [1:0]          p0_bl,
    input  logic [MCB_B_W-1:0]  p0_ba,
    input  logic [MCB_R_W-1:0]  p0_ra,
    input  logic [MCB_C_W-1:0]  p0_ca,
    output logic                p0_gnt,
    output logic                p0_rdat_vld,
    output logic [MCB_D_W-1:0]  p0_rdat,
    output logic                p0_wdat_req,
    input  logic [MCB_D_W-1:0]  p0_wdat,
    input  logic [MCB_BE_W-1:0] p0_wbe,
    input  logic                p1_req,
    input  logic                p1_wr_n,
    input  logic [1:0]          p1_bl,
    input  logic [MCB_B_W-1:0]  p1_ba,
    input  logic [MCB_R_W-1:0]  p1_ra,
    input  logic [MCB_C_W-1:0]  p1_ca,
    output logic                p1_gnt,
    output logic                p1_rdat_vld,
    output logic [MCB_D_W-1:0]  p1_rdat,
    output logic                p1_wdat_req,
    input  logic [MCB_D_W-1:0]  p1_wdat,
    input  logic [MCB_BE_W-1:0] p1_wbe,
    output logic                mcb_bb,
    output logic                mcb_wr_n,
    output logic [1:0]          mcb_bl,
    output logic [MCB_B_W-1:0]  mcb_ba,
    output logic [MCB_R_W-1:0]  mcb_ra,
    output logic [MCB_C_W-1:0]  mcb_ca,
    input  logic                mcb_busy,
    input  logic                mcb_i_ready,
    input  logic                mcb_rdat_vld,
    input  logic [MCB_D_W-1:0]  mcb_rdat,
    input  logic                mcb_wdat_req,
    output logic [MCB_D_W-1:0]  mcb_wdat,
    output logic [MCB_BE_W-1:0] mcb_wbe,
    output logic                err,
    output arb_state_t          dbg_state
);

    // Requesters hold req and fields until their gnt pulse; gnt marks the
    // cycle mcb_bb presents the command, and the requester drops req after it.

    arb_state_t         state_q, state_d;
    logic               last_q, last_d;
    logic               bb_q, bb_d;
    logic               wr_n_q, wr_n_d;
    logic [1:0]         bl_q, bl_d;
    logic [MCB_B_W-1:0] ba_q, ba_d;
    logic [MCB_R_W-1:0] ra_q, ra_d;
    logic [MCB_C_W-1:0] ca_q, ca_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         rdat_vld_q, rdat_vld_d;
    logic [MCB_D_W-1:0] p0_rdat_q, p0_rdat_d;
    logic [MCB_D_W-1:0] p1_rdat_q, p1_rdat_d;
    logic [2:0]         rd_beat_q, rd_beat_d;
    logic [2:0]         wr_beat_q, wr_beat_d;
    logic               err_q, err_d;

    logic elig0, elig1, win, issue;
    logic rd_push, rd_pop, rd_full, rd_empty, rd_hit;
    logic wr_push, wr_pop, wr_full, wr_empty, wr_hit;
    tag_t rd_head, wr_head, push_tag;

    mcb_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_rd_fifo (
        .clk(mcb_clk), .rst(mcb_rst), .push(rd_push), .push_data(push_tag),
        .pop(rd_pop), .head(rd_head), .full(rd_full), .empty(rd_empty)
    );

    mcb_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_wr_fifo (
        .clk(mcb_clk), .rst(mcb_rst), .push(wr_push), .push_data(push_tag),
        .pop(wr_pop), .head(wr_head), .full(wr_full), .empty(wr_empty)
    );

    // A port only competes if the FIFO for its command type has room.
    always_comb begin
        elig0 = p0_req && (p0_wr_n ? !rd_full : !wr_full);
        elig1 = p1_req && (p1_wr_n ? !rd_full : !wr_full);
        win   = (elig0 && elig1) ? ~last_q : elig1;
        issue = (state_q == ST_IDLE) && mcb_i_ready && !mcb_busy && (elig0 || elig1);
        push_tag.port = win;
        push_tag.bl   = win ? p1_bl : p0_bl;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bb_d    = 1'b0;
        wr_n_d  = wr_n_q;
        bl_d    = bl_q;
        ba_d    = ba_q;
        ra_d    = ra_q;
        ca_d    = ca_q;
        gnt_d   = 2'b00;
        rd_push = 1'b0;
        wr_push = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d    = ST_ISSUE;
                    last_d     = win;
                    bb_d       = 1'b1;
                    wr_n_d     = win ? p1_wr_n : p0_wr_n;
                    bl_d       = win ? p1_bl : p0_bl;
                    ba_d       = win ? p1_ba : p0_ba;
                    ra_d       = win ? p1_ra : p0_ra;
                    ca_d       = win ? p1_ca : p0_ca;
                    gnt_d[win] = 1'b1;
                    rd_push    = wr_n_d;
                    wr_push    = !wr_n_d;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_hit     = mcb_rdat_vld && !rd_empty;
        rdat_vld_d = 2'b00;
        p0_rdat_d  = p0_rdat_q;
        p1_rdat_d  = p1_rdat_q;
        rd_beat_d  = rd_beat_q;
        rd_pop     = 1'b0;
        if (rd_hit) begin
            rdat_vld_d[rd_head.port] = 1'b1;
            if (rd_head.port == 1'b0) p0_rdat_d = mcb_rdat;
            else                      p1_rdat_d = mcb_rdat;
            if ({1'b0, rd_beat_q} == bl_beats(rd_head.bl) - 4'd1) begin
                rd_pop    = 1'b1;
                rd_beat_d = 3'd0;
            end else begin
                rd_beat_d = rd_beat_q + 3'd1;
            end
        end

        wr_hit    = mcb_wdat_req && !wr_empty;
        wr_beat_d = wr_beat_q;
        wr_pop    = 1'b0;
        if (wr_hit) begin
            if ({1'b0, wr_beat_q} == bl_beats(wr_head.bl) - 4'd1) begin
                wr_pop    = 1'b1;
                wr_beat_d = 3'd0;
            end else begin
                wr_beat_d = wr_beat_q + 3'd1;
            end
        end

        // Stray beats with nothing outstanding are dropped and latch err.
        err_d = err_q || (mcb_rdat_vld && rd_empty) || (mcb_wdat_req && wr_empty);
    end

    always_comb begin
        p0_wdat_req = wr_hit && (wr_head.port == 1'b0);
        p1_wdat_req = wr_hit && (wr_head.port == 1'b1);
        mcb_wdat    = '0;
        mcb_wbe     = '0;
        if (!wr_empty) begin
            mcb_wdat = wr_head.port ? p1_wdat : p0_wdat;
            mcb_wbe  = wr_head.port ? p1_wbe : p0_wbe;
        end
    end

    always_ff @(posedge mcb_clk) begin
        if (mcb_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            bb_q       <= 1'b0;
            wr_n_q     <= 1'b1;
            bl_q       <= '0;
            ba_q       <= '0;
            ra_q       <= '0;
            ca_q       <= '0;
            gnt_q      <= '0;
            rdat_vld_q <= '0;
            p0_rdat_q  <= '0;
            p1_rdat_q  <= '0;
            rd_beat_q  <= '0;
            wr_beat_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            bb_q       <= bb_d;
            wr_n_q     <= wr_n_d;
            bl_q       <= bl_d;
            ba_q       <= ba_d;
            ra_q       <= ra_d;
            ca_q       <= ca_d;
            gnt_q      <= gnt_d;
            rdat_vld_q <= rdat_vld_d;
            p0_rdat_q  <= p0_rdat_d;
            p1_rdat_q  <= p1_rdat_d;
            rd_beat_q  <= rd_beat_d;
            wr_beat_q  <= wr_beat_d;
            err_q      <= err_d;
        end
    end

    assign mcb_bb      = bb_q;
    assign mcb_wr_n    = wr_n_q;
    assign mcb_bl      = bl_q;
    assign mcb_ba      = ba_q;
    assign mcb_ra      = ra_q;
    assign mcb_ca      = ca_q;
    assign p0_gnt      = gnt_q[0];
    assign p1_gnt      = gnt_q[1];
    assign p0_rdat_vld = rdat_vld_q[0];
    assign p1_rdat_vld = rdat_vld_q[1];
    assign p0_rdat     = p0_rdat_q;
    assign p1_rdat     = p1_rdat_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcb_port_arb.sv
// Directed bench for mcb_port_arb: grants, routing, back-pressure, errors, reset.
module tb_mcb_port_arb;
    import mcb_arb_pkg::*;

    logic        mcb_clk = 1'b0;
    logic        mcb_rst;
    logic        p0_req, p0_wr_n, p1_req, p1_wr_n;
    logic [1:0]  p0_bl, p1_bl;
    logic [1:0]  p0_ba, p1_ba;
    logic [12:0] p0_ra, p1_ra;
    logic [8:0]  p0_ca, p1_ca;
    logic        p0_gnt, p1_gnt, p0_rdat_vld, p1_rdat_vld, p0_wdat_req, p1_wdat_req;
    logic [31:0] p0_rdat, p1_rdat, p0_wdat, p1_wdat;
    logic [3:0]  p0_wbe, p1_wbe;
    logic        mcb_bb, mcb_wr_n;
    logic [1:0]  mcb_bl, mcb_ba;
    logic [12:0] mcb_ra;
    logic [8:0]  mcb_ca;
    logic        mcb_busy, mcb_i_ready, mcb_rdat_vld, mcb_wdat_req;
    logic [31:0] mcb_rdat, mcb_wdat;
    logic [3:0]  mcb_wbe;
    logic        err;
    arb_state_t  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 mcb_clk = ~mcb_clk;

    mcb_port_arb dut (
        .mcb_clk(mcb_clk), .mcb_rst(mcb_rst),
        .p0_req(p0_req), .p0_wr_n(p0_wr_n), .p0_bl(p0_bl), .p0_ba(p0_ba), .p0_ra(p0_ra), .p0_ca(p0_ca),
        .p0_gnt(p0_gnt), .p0_rdat_vld(p0_rdat_vld), .p0_rdat(p0_rdat), .p0_wdat_req(p0_wdat_req),
        .p0_wdat(p0_wdat), .p0_wbe(p0_wbe),
        .p1_req(p1_req), .p1_wr_n(p1_wr_n), .p1_bl(p1_bl), .p1_ba(p1_ba), .p1_ra(p1_ra), .p1_ca(p1_ca),
        .p1_gnt(p1_gnt), .p1_rdat_vld(p1_rdat_vld), .p1_rdat(p1_rdat), .p1_wdat_req(p1_wdat_req),
        .p1_wdat(p1_wdat), .p1_wbe(p1_wbe),
        .mcb_bb(mcb_bb), .mcb_wr_n(mcb_wr_n), .mcb_bl(mcb_bl), .mcb_ba(mcb_ba), .mcb_ra(mcb_ra), .mcb_ca(mcb_ca),
        .mcb_busy(mcb_busy), .mcb_i_ready(mcb_i_ready), .mcb_rdat_vld(mcb_rdat_vld), .mcb_rdat(mcb_rdat),
        .mcb_wdat_req(mcb_wdat_req), .mcb_wdat(mcb_wdat), .mcb_wbe(mcb_wbe),
        .err(err), .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge mcb_clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_wr_n = 1; p0_bl = 0; p0_ba = 0; p0_ra = 0; p0_ca = 0; p0_wdat = 0; p0_wbe = 0;
        p1_req = 0; p1_wr_n = 1; p1_bl = 0; p1_ba = 0; p1_ra = 0; p1_ca = 0; p1_wdat = 0; p1_wbe = 0;
        mcb_busy = 0; mcb_i_ready = 1; mcb_rdat_vld = 0; mcb_rdat = 0; mcb_wdat_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mcb_rst = 1;
        step();
        step();
        mcb_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mcb_bb !== 1'b0) begin errors++; $display("FAIL rst_bb got %b exp 0", mcb_bb); end
        checks++; if (mcb_wr_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n got %b exp 1", mcb_wr_n); end
        checks++; if ({mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== '0) begin errors++; $display("FAIL rst_fields got %h exp 0", {mcb_bl, mcb_ba, mcb_ra, mcb_ca}); end
        checks++; if ({p0_gnt, p1_gnt, p0_rdat_vld, p1_rdat_vld, p0_wdat_req, p1_wdat_req, err} !== 7'b0) begin errors++; $display("FAIL rst_strobes got %b exp 0", {p0_gnt, p1_gnt, p0_rdat_vld, p1_rdat_vld, p0_wdat_req, p1_wdat_req, err}); end
        checks++; if ({p0_rdat, p1_rdat} !== 64'h0) begin errors++; $display("FAIL rst_rdat got %h exp 0", {p0_rdat, p1_rdat}); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state); end
    endtask

    task automatic test_single_read();
        do_reset();
        p0_req = 1; p0_wr_n = 1; p0_bl = 2'b10; p0_ba = 2'd1; p0_ra = 13'h123; p0_ca = 9'h040;
        step();
        checks++; if ({mcb_bb, p0_gnt, p1_gnt, mcb_wr_n} !== 4'b1101) begin errors++; $display("FAIL rd_issue got %b exp 1101", {mcb_bb, p0_gnt, p1_gnt, mcb_wr_n}); end
        checks++; if ({mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== {2'b10, 2'd1, 13'h123, 9'h040}) begin errors++; $display("FAIL rd_fields got %h exp %h", {mcb_bl, mcb_ba, mcb_ra, mcb_ca}, {2'b10, 2'd1, 13'h123, 9'h040}); end
        checks++; if (dbg_state !== ST_ISSUE) begin errors++; $display("FAIL rd_state got %0d exp 1", dbg_state); end
        p0_req = 0;
        step();
        checks++; if ({mcb_bb, p0_gnt} !== 2'b00) begin errors++; $display("FAIL rd_one_pulse got %b exp 00", {mcb_bb, p0_gnt}); end
        for (int i = 0; i < 4; i++) begin
            mcb_rdat_vld = 1; mcb_rdat = 32'hD000_0000 + i;
            step();
            checks++; if ({p0_rdat_vld, p1_rdat_vld} !== 2'b10 || p0_rdat !== 32'hD000_0000 + i) begin errors++; $display("FAIL rd_beat%0d got %b/%h exp 10/%h", i, {p0_rdat_vld, p1_rdat_vld}, p0_rdat, 32'hD000_0000 + i); end
        end
        mcb_rdat_vld = 0;
        step();
        checks++; if ({p0_rdat_vld, err} !== 2'b00) begin errors++; $display("FAIL rd_done got %b exp 00", {p0_rdat_vld, err}); end
    endtask

    task automatic test_round_robin();
        logic e0, e1;
        do_reset();
        p0_req = 1; p0_wr_n = 1; p1_req = 1; p1_wr_n = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            e0 = (i == 0 || i == 4);
            e1 = (i == 2 || i == 6);
            checks++; if ({mcb_bb, p0_gnt, p1_gnt} !== {e0 | e1, e0, e1}) begin errors++; $display("FAIL rr_cyc%0d got %b exp %b", i, {mcb_bb, p0_gnt, p1_gnt}, {e0 | e1, e0, e1}); end
        end
        p0_req = 0; p1_req = 0;
        for (int j = 0; j < 4; j++) begin
            mcb_rdat_vld = 1; mcb_rdat = 32'hA0 + j;
            step();
            checks++; if ({p0_rdat_vld, p1_rdat_vld} !== {j % 2 == 0, j % 2 == 1} || ((j % 2 == 0) ? p0_rdat : p1_rdat) !== 32'hA0 + j) begin errors++; $display("FAIL rr_ret%0d got %b exp %b", j, {p0_rdat_vld, p1_rdat_vld}, {j % 2 == 0, j % 2 == 1}); end
        end
        mcb_rdat_vld = 0;
    endtask

    task automatic test_write_with_read();
        do_reset();
        p0_req = 1; p0_wr_n = 1; p0_bl = 2'b10;
        step();
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("FAIL wr_rdgnt got %b exp 1", p0_gnt); end
        p0_req = 0;
        p1_req = 1; p1_wr_n = 0; p1_bl = 2'b11; p1_ba = 2'd2; p1_ra = 13'h0AA; p1_ca = 9'h011;
        step();
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("FAIL wr_issue_gap got %b exp 0", p1_gnt); end
        step();
        checks++; if ({p1_gnt, mcb_wr_n, mcb_bl, mcb_ra} !== {1'b1, 1'b0, 2'b11, 13'h0AA}) begin errors++; $display("FAIL wr_issue got %h exp %h", {p1_gnt, mcb_wr_n, mcb_bl, mcb_ra}, {1'b1, 1'b0, 2'b11, 13'h0AA}); end
        p1_req = 0;
        for (int i = 0; i < 8; i++) begin
            mcb_wdat_req = 1; p1_wdat = 32'h1000_0000 + i; p1_wbe = 4'(i + 1);
            p0_wdat = 32'hDEAD_BEEF; p0_wbe = 4'hF;
            mcb_rdat_vld = (i < 4); mcb_rdat = 32'hB0 + i;
            #1;
            checks++; if ({p0_wdat_req, p1_wdat_req} !== 2'b01 || mcb_wdat !== p1_wdat || mcb_wbe !== p1_wbe) begin errors++; $display("FAIL wr_beat%0d got %b/%h/%h exp 01/%h/%h", i, {p0_wdat_req, p1_wdat_req}, mcb_wdat, mcb_wbe, p1_wdat, p1_wbe); end
            step();
            checks++; if ({p0_rdat_vld, p1_rdat_vld} !== {i < 4, 1'b0} || (i < 4 && p0_rdat !== 32'hB0 + i)) begin errors++; $display("FAIL wr_rdret%0d got %b/%h exp %b", i, {p0_rdat_vld, p1_rdat_vld}, p0_rdat, {i < 4, 1'b0}); end
        end
        mcb_wdat_req = 0; mcb_rdat_vld = 0;
        #1;
        checks++; if ({mcb_wdat, p1_wdat_req, err} !== 34'h0) begin errors++; $display("FAIL wr_drained got %h exp 0", {mcb_wdat, p1_wdat_req, err}); end
    endtask

    task automatic test_fifo_full();
        int g;
        do_reset();
        g = 0;
        p0_req = 1; p0_wr_n = 1; p0_bl = 2'b00;
        for (int i = 0; i < 8; i++) begin step(); g += p0_gnt; end
        checks++; if (g !== 4) begin errors++; $display("FAIL full_fill got %0d exp 4", g); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (p0_gnt !== 1'b0) begin errors++; $display("FAIL full_block%0d got %b exp 0", i, p0_gnt); end
        end
        p1_req = 1; p1_wr_n = 0; p1_bl = 2'b00;
        step();
        checks++; if ({p0_gnt, p1_gnt} !== 2'b01) begin errors++; $display("FAIL full_wr_pass got %b exp 01", {p0_gnt, p1_gnt}); end
        p1_req = 0;
        step();
        mcb_rdat_vld = 1;
        step();
        checks++; if ({p0_gnt, p0_rdat_vld} !== 2'b01) begin errors++; $display("FAIL full_ret got %b exp 01", {p0_gnt, p0_rdat_vld}); end
        mcb_rdat_vld = 0;
        step();
        checks++; if ({mcb_bb, p0_gnt} !== 2'b11) begin errors++; $display("FAIL full_5th got %b exp 11", {mcb_bb, p0_gnt}); end
        p0_req = 0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        mcb_busy = 1; p0_req = 1; p0_wr_n = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({mcb_bb, p0_gnt, p1_gnt} !== 3'b000) begin errors++; $display("FAIL busy%0d got %b exp 000", i, {mcb_bb, p0_gnt, p1_gnt}); end
        end
        mcb_busy = 0;
        step();
        checks++; if ({mcb_bb, p0_gnt} !== 2'b11) begin errors++; $display("FAIL busy_clear got %b exp 11", {mcb_bb, p0_gnt}); end
        p0_req = 0;
        step();
        mcb_i_ready = 0; p1_req = 1; p1_wr_n = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if ({mcb_bb, p0_gnt, p1_gnt} !== 3'b000) begin errors++; $display("FAIL nrdy%0d got %b exp 000", i, {mcb_bb, p0_gnt, p1_gnt}); end
        end
        mcb_i_ready = 1;
        step();
        checks++; if ({mcb_bb, p1_gnt} !== 2'b11) begin errors++; $display("FAIL nrdy_clear got %b exp 11", {mcb_bb, p1_gnt}); end
        p1_req = 0;
        step();
    endtask

    task automatic test_err();
        do_reset();
        mcb_rdat_vld = 1; mcb_rdat = 32'h1234;
        step();
        checks++; if ({err, p0_rdat_vld, p1_rdat_vld} !== 3'b100) begin errors++; $display("FAIL err_set got %b exp 100", {err, p0_rdat_vld, p1_rdat_vld}); end
        mcb_rdat_vld = 0;
        step(); step(); step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_hold got %b exp 1", err); end
        mcb_wdat_req = 1; p0_wdat = 32'h55; p0_wbe = 4'h3;
        #1;
        checks++; if ({p0_wdat_req, p1_wdat_req, mcb_wdat, mcb_wbe} !== 38'h0) begin errors++; $display("FAIL err_wdrop got %h exp 0", {p0_wdat_req, p1_wdat_req, mcb_wdat, mcb_wbe}); end
        mcb_wdat_req = 0;
    endtask

    task automatic test_reset_mid_write();
        p0_req = 1; p0_wr_n = 0; p0_bl = 2'b11; p0_ba = 2'd3; p0_ra = 13'h1FFF; p0_ca = 9'h1FF;
        step();
        checks++; if ({p0_gnt, mcb_wr_n, mcb_ra} !== {1'b1, 1'b0, 13'h1FFF}) begin errors++; $display("FAIL mrst_issue got %h exp %h", {p0_gnt, mcb_wr_n, mcb_ra}, {1'b1, 1'b0, 13'h1FFF}); end
        p0_req = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            mcb_wdat_req = 1; p0_wdat = 32'hC0 + i;
            #1;
            checks++; if ({p0_wdat_req, mcb_wdat} !== {1'b1, 32'hC0 + i}) begin errors++; $display("FAIL mrst_beat%0d got %h exp %h", i, {p0_wdat_req, mcb_wdat}, {1'b1, 32'hC0 + i}); end
            step();
        end
        mcb_wdat_req = 0; mcb_rst = 1;
        step();
        checks++; if ({mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca} !== {1'b0, 1'b1, 26'h0}) begin errors++; $display("FAIL mrst_cmd got %h exp %h", {mcb_bb, mcb_wr_n, mcb_bl, mcb_ba, mcb_ra, mcb_ca}, {1'b0, 1'b1, 26'h0}); end
        checks++; if ({p0_gnt, p1_gnt, p0_rdat_vld, p1_rdat_vld, err, dbg_state} !== 6'b0) begin errors++; $display("FAIL mrst_flags got %b exp 0", {p0_gnt, p1_gnt, p0_rdat_vld, p1_rdat_vld, err, dbg_state}); end
        mcb_rst = 0;
        mcb_wdat_req = 1;
        #1;
        checks++; if ({p0_wdat_req, mcb_wdat} !== 33'h0) begin errors++; $display("FAIL mrst_empty got %h exp 0", {p0_wdat_req, mcb_wdat}); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mrst_err got %b exp 1", err); end
        mcb_wdat_req = 0;
        do_reset();
    endtask

    initial begin
        idle_inputs();
        mcb_rst = 1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_with_read();
        test_fifo_full();
        test_stall();
        test_err();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
